// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one 32-bit memory port between instruction fetch (port 0) and data
// access (port 1). A request is granted in IDLE, the grant is held for the
// whole memory transaction, and the winner gets the read data plus a
// one-cycle done pulse one cycle after mem_ack. Address and write data reach
// the memory through mux2x1, so the memory only ever sees the granted port.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> a tie goes to ~last_grant (alternates)
//                       undefined -> fixed priority, data port wins every tie
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req0, addr0, done0  fetch requester: request, address, completion pulse
//   req1, we1, addr1,
//   wdata1, done1       data requester: request, write enable, address,
//                       write value, completion pulse
//   rdata               read data, valid in a done0/done1 cycle
//   mem_req, mem_we,
//   mem_addr, mem_wdata memory request side
//   mem_ack, mem_rdata  memory completion pulse and read data
//   sel                 granted port (0 = fetch, 1 = data)
//   busy                transaction in flight
// ---------------------------------------------------------------------------

// Fixed 32-bit two-input multiplexer: y = sel ? in1 : in0.
module mux2x1 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        sel,
    output logic [31:0] y
);
    assign y = sel ? in1 : in0;
endmodule

// State table:
//   state | meaning
//   IDLE  | no transaction; arbitrate req0/req1, register the winner in sel
//   BUSY  | mem_req held for the granted port until mem_ack
module mem_port_arbiter #(
    parameter int AW = 32,  // must be 32: mux2x1 is fixed width
    parameter int DW = 32   // must be 32: mux2x1 is fixed width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          sel,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          tie_pick;
    logic          winner;
    logic          in_busy;

    // Who wins when both ports request in the same IDLE cycle.
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last_grant_q;
`else
    // Data port always wins; last_grant is still tracked so both builds
    // carry the same state, it just has no influence here.
    assign tie_pick = last_grant_q | 1'b1;
`endif

    assign winner = (req0 & req1) ? tie_pick : req1;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                // mem_ack here is stray and ignored.
                if (req0 | req1) begin
                    sel_d   = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped request does not abort; we wait for mem_ack.
                if (mem_ack) begin
                    rdata_d      = mem_rdata;
                    done0_d      = ~sel_q;
                    done1_d      = sel_q;
                    last_grant_d = sel_q;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata_q      <= rdata_d;
        end
    end

    assign in_busy = (state_q == BUSY);
    assign mem_req = in_busy;
    assign busy    = in_busy;
    assign mem_we  = in_busy & sel_q & we1;
    assign sel     = sel_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata   = rdata_q;

    mux2x1 u_addr_mux (
        .in0 (addr0),
        .in1 (addr1),
        .sel (sel_q),
        .y   (mem_addr)
    );

    // Fetch never writes, so port 0 contributes zero write data.
    mux2x1 u_wdata_mux (
        .in0 ('0),
        .in1 (wdata1),
        .sel (sel_q),
        .y   (mem_wdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we1;
    logic [31:0] addr0, addr1, wdata1;
    logic        done0, done1;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        sel, busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .addr0     (addr0),
        .done0     (done0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .done1     (done1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sel       (sel),
        .busy      (busy)
    );

    // Tie winner expected from reset state (last_grant = 1).
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] TIE_ORDER = 4'b1010;  // bit i = grant i: 0,1,0,1
    localparam logic       TIE_AFTER_RST = 1'b0;
`else
    localparam logic [3:0] TIE_ORDER = 4'b1111;  // 1,1,1,1
    localparam logic       TIE_AFTER_RST = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-port transaction; ack raised dly cycles after mem_req is first seen.
    task automatic single_txn(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly);
        req0 = ~port;
        req1 = port;
        if (port) begin
            addr1 = addr; we1 = we; wdata1 = wd;
        end else begin
            addr0 = addr;
        end
        tick();
        chk("txn_mem_req", {31'b0, mem_req}, 32'd1);
        chk("txn_busy", {31'b0, busy}, 32'd1);
        chk("txn_sel", {31'b0, sel}, {31'b0, port});
        chk("txn_mem_addr", mem_addr, addr);
        chk("txn_mem_we", {31'b0, mem_we}, {31'b0, port & we});
        chk("txn_mem_wdata", mem_wdata, port ? wd : 32'h0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("txn_hold_req", {31'b0, mem_req}, 32'd1);
            chk("txn_no_early_done", {30'b0, done1, done0}, 32'd0);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("txn_done0", {31'b0, done0}, {31'b0, ~port});
        chk("txn_done1", {31'b0, done1}, {31'b0, port});
        chk("txn_rdata", rdata, rd);
        chk("txn_bubble", {31'b0, mem_req}, 32'd0);
        tick();
        chk("txn_done_len", {30'b0, done1, done0}, 32'd0);
        chk("txn_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata1 = 0;
        mem_ack = 0; mem_rdata = 0;

        // 1: reset state
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_sel", {31'b0, sel}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {30'b0, done1, done0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // 2: fetch read, ack 3 cycles after mem_req
        single_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);

        // 3: data write, ack after 1 cycle
        single_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'h0BAD_F00D, 1);

        // 4: continuous contention for 4 transactions (last_grant = 1 here)
        addr0 = 32'h0000_0A00;
        addr1 = 32'h0000_0B00;
        we1 = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("cont_mem_req", {31'b0, mem_req}, 32'd1);
            chk("cont_sel", {31'b0, sel}, {31'b0, TIE_ORDER[i]});
            chk("cont_addr", mem_addr, TIE_ORDER[i] ? 32'h0000_0B00 : 32'h0000_0A00);
            mem_ack = 1'b1;
            mem_rdata = 32'hA5A5_0000 + i;
            tick();
            mem_ack = 1'b0;
            chk("cont_done0", {31'b0, done0}, {31'b0, ~TIE_ORDER[i]});
            chk("cont_done1", {31'b0, done1}, {31'b0, TIE_ORDER[i]});
            chk("cont_rdata", rdata, 32'hA5A5_0000 + i);
            chk("cont_bubble", {31'b0, mem_req}, 32'd0);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
        end
        chk("cont_end_idle", {31'b0, mem_req}, 32'd0);

        // 5: leave last_grant = 0, then reset in the middle of a data txn
        single_txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 0);
        req1 = 1'b1;
        addr1 = 32'h0000_0400;
        tick();
        chk("rstb_pre_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstb_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstb_busy", {31'b0, busy}, 32'd0);
        chk("rstb_sel", {31'b0, sel}, 32'd0);
        chk("rstb_rdata", rdata, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        chk("rstb_no_done", {30'b0, done1, done0}, 32'd0);
        chk("rstb_rdata_kept", rdata, 32'd0);
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 32'h0000_0C00;
        tick();
        chk("rstb_tie_sel", {31'b0, sel}, {31'b0, TIE_AFTER_RST});
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_0001;
        tick();
        mem_ack = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rstb_tie_done", {30'b0, done1, done0}, TIE_AFTER_RST ? 32'd2 : 32'd1);
        tick();

        // 6: stray ack in IDLE
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        chk("stray_no_done", {30'b0, done1, done0}, 32'd0);
        chk("stray_rdata", rdata, 32'h7777_0001);
        chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("stray_no_done_late", {30'b0, done1, done0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
